// File: rtl/ucsbece154a_mc_controller.sv
// Main control FSM for the multicycle RISC-V core.
// Sequences the shared ALU, unified memory port and register file across
// fetch/decode/execute/memory/writeback steps, and exports cycle/instret
// performance counters plus a one-cycle illegal-opcode pulse.
// Optional macro MC_MEM_WAIT_EN adds mem_ready_i so FETCH, MEMREAD and
// MEMWRITE can stall on a slow memory; without it memory is always ready.
module ucsbece154a_mc_controller #(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           op_i,
   input  logic                 zero_i,
`ifdef MC_MEM_WAIT_EN
   input  logic                 mem_ready_i,
`endif
   output logic                 PCWrite_o,
   output logic                 AdrSrc_o,
   output logic                 MemWrite_o,
   output logic                 IRWrite_o,
   output logic [1:0]           ResultSrc_o,
   output logic [1:0]           ALUSrcA_o,
   output logic [1:0]           ALUSrcB_o,
   output logic [1:0]           ALUOp_o,
   output logic [1:0]           ImmSrc_o,
   output logic                 RegWrite_o,
   output logic                 illegal_o,
   output logic [3:0]           state_o,
   output logic [CNT_WIDTH-1:0] cycle_o,
   output logic [CNT_WIDTH-1:0] instret_o
);

   localparam logic [6:0] OpLw   = 7'b0000011;
   localparam logic [6:0] OpSw   = 7'b0100011;
   localparam logic [6:0] OpR    = 7'b0110011;
   localparam logic [6:0] OpI    = 7'b0010011;
   localparam logic [6:0] OpBeq  = 7'b1100011;
   localparam logic [6:0] OpJal  = 7'b1101111;

   localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBeq      = 4'd9,
      StJal      = 4'd10
   } state_t;

   state_t               state_q;
   logic                 illegal_q;
   logic [CNT_WIDTH-1:0] cycle_q;
   logic [CNT_WIDTH-1:0] instret_q;

   logic mem_ready;
`ifdef MC_MEM_WAIT_EN
   assign mem_ready = mem_ready_i;
`else
   assign mem_ready = 1'b1;
`endif

   logic       pc_update;
   logic       branch;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;

   // State register, illegal pulse and performance counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StFetch;
         illegal_q <= 1'b0;
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         cycle_q   <= cycle_q + CntOne;
         illegal_q <= 1'b0;
         unique case (state_q)
            StFetch:    if (mem_ready) state_q <= StDecode;
            StDecode: begin
               unique case (op_i)
                  OpLw, OpSw: state_q <= StMemAdr;
                  OpR:        state_q <= StExecR;
                  OpI:        state_q <= StExecI;
                  OpBeq:      state_q <= StBeq;
                  OpJal:      state_q <= StJal;
                  default: begin
                     state_q   <= StFetch;
                     illegal_q <= 1'b1;
                  end
               endcase
            end
            StMemAdr:   state_q <= (op_i == OpLw) ? StMemRead : StMemWrite;
            StMemRead:  if (mem_ready) state_q <= StMemWb;
            StMemWb: begin
               state_q   <= StFetch;
               instret_q <= instret_q + CntOne;
            end
            StMemWrite: begin
               if (mem_ready) begin
                  state_q   <= StFetch;
                  instret_q <= instret_q + CntOne;
               end
            end
            StExecR:    state_q <= StAluWb;
            StExecI:    state_q <= StAluWb;
            StAluWb, StBeq: begin
               state_q   <= StFetch;
               instret_q <= instret_q + CntOne;
            end
            StJal:      state_q <= StAluWb;
            default:    state_q <= StFetch;
         endcase
      end
   end

   // Moore control decode; FETCH strobes only fire on the cycle memory answers
   always_comb begin
      pc_update  = 1'b0;
      branch     = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      unique case (state_q)
         StFetch: begin
            ir_write   = mem_ready;
            pc_update  = mem_ready;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         StDecode:   alu_src_a = 2'b01;
         StMemAdr:   alu_src_a = 2'b10;
         StMemRead:  adr_src = 1'b1;
         StMemWb: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         StMemWrite: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         StExecR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         StExecI: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         StAluWb:    reg_write = 1'b1;
         StBeq: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b01;
            branch    = 1'b1;
         end
         StJal: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
         end
         default: ;
      endcase
   end

   // Immediate format depends only on the opcode in the instruction register
   always_comb begin
      unique case (op_i)
         OpSw:    ImmSrc_o = 2'b01;
         OpBeq:   ImmSrc_o = 2'b10;
         OpJal:   ImmSrc_o = 2'b11;
         default: ImmSrc_o = 2'b00;
      endcase
   end

   // Architectural write enables are suppressed while reset is held
   assign PCWrite_o   = ~reset & (pc_update | (branch & zero_i));
   assign IRWrite_o   = ~reset & ir_write;
   assign RegWrite_o  = ~reset & reg_write;
   assign MemWrite_o  = ~reset & mem_write;
   assign AdrSrc_o    = adr_src;
   assign ResultSrc_o = result_src;
   assign ALUSrcA_o   = alu_src_a;
   assign ALUSrcB_o   = alu_src_b;
   assign ALUOp_o     = alu_op;
   assign illegal_o   = illegal_q;
   assign state_o     = state_q;
   assign cycle_o     = cycle_q;
   assign instret_o   = instret_q;

endmodule

// File: tb/tb_ucsbece154a_mc_controller.sv
// Self-checking bench for ucsbece154a_mc_controller.
// Expected behaviour comes from per-instruction step lists and the control
// table of each step; counters use a narrow width so wrap-around is reached.
// Define MC_MEM_WAIT_EN to also exercise random memory stalls.
module tb_ucsbece154a_mc_controller;

   localparam int unsigned CW = 4;

   localparam logic [6:0] OpLw  = 7'b0000011;
   localparam logic [6:0] OpSw  = 7'b0100011;
   localparam logic [6:0] OpR   = 7'b0110011;
   localparam logic [6:0] OpI   = 7'b0010011;
   localparam logic [6:0] OpBeq = 7'b1100011;
   localparam logic [6:0] OpJal = 7'b1101111;

   logic          clk = 1'b0;
   logic          reset;
   logic [6:0]    op;
   logic          zero;
   logic          mem_ready;
   logic          pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
   logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op, imm_src;
   logic [3:0]    state;
   logic [CW-1:0] cycle_cnt, instret_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int   m_cycle = 0;
   int   m_instret = 0;
   logic m_illegal_pending = 1'b0;

   always #5 clk = ~clk;

   ucsbece154a_mc_controller #(.CNT_WIDTH(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .op_i        (op),
      .zero_i      (zero),
`ifdef MC_MEM_WAIT_EN
      .mem_ready_i (mem_ready),
`endif
      .PCWrite_o   (pc_write),
      .AdrSrc_o    (adr_src),
      .MemWrite_o  (mem_write),
      .IRWrite_o   (ir_write),
      .ResultSrc_o (result_src),
      .ALUSrcA_o   (alu_src_a),
      .ALUSrcB_o   (alu_src_b),
      .ALUOp_o     (alu_op),
      .ImmSrc_o    (imm_src),
      .RegWrite_o  (reg_write),
      .illegal_o   (illegal),
      .state_o     (state),
      .cycle_o     (cycle_cnt),
      .instret_o   (instret_cnt)
   );

   function automatic bit is_legal(input logic [6:0] o);
      return (o == OpLw) || (o == OpSw) || (o == OpR) || (o == OpI) ||
             (o == OpBeq) || (o == OpJal);
   endfunction

   // Control table: {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
   // ALUSrcB, ALUOp, ImmSrc, RegWrite}
   function automatic logic [14:0] exp_ctrl(input int st, input logic [6:0] o,
                                            input logic z, input logic rdy,
                                            input logic rst);
      logic pcw, adr, mw, irw, rw;
      logic [1:0] rs, sa, sb, aop, imm;
      pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
      rs = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
      imm = (o == OpSw) ? 2'b01 : (o == OpBeq) ? 2'b10 : (o == OpJal) ? 2'b11 : 2'b00;
      case (st)
         0:  begin irw = rdy; pcw = rdy; sb = 2'b10; rs = 2'b10; end
         1:  sa = 2'b01;
         2:  sa = 2'b10;
         3:  adr = 1;
         4:  begin rs = 2'b01; rw = 1; end
         5:  begin adr = 1; mw = 1; end
         6:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
         7:  begin sa = 2'b10; aop = 2'b10; end
         8:  rw = 1;
         9:  begin sa = 2'b10; sb = 2'b01; aop = 2'b01; pcw = z; end
         10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
         default: ;
      endcase
      if (rst) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
      return {pcw, adr, mw, irw, rs, sa, sb, aop, imm, rw};
   endfunction

   function automatic logic pick_ready();
`ifdef MC_MEM_WAIT_EN
      return ($urandom_range(0, 3) != 0);
`else
      return 1'b1;
`endif
   endfunction

   task automatic build_seq(input logic [6:0] o, output int seq[$]);
      case (o)
         OpLw:    seq = '{0, 1, 2, 3, 4};
         OpSw:    seq = '{0, 1, 2, 5};
         OpR:     seq = '{0, 1, 6, 8};
         OpI:     seq = '{0, 1, 7, 8};
         OpBeq:   seq = '{0, 1, 9};
         OpJal:   seq = '{0, 1, 10, 8};
         default: seq = '{0, 1};
      endcase
   endtask

   // One cycle: drive at negedge, compare everything against the model
   task automatic check_cycle(input string name, input int st, input logic rst,
                              input logic first);
      logic [14:0]   got, exp;
      logic [CW-1:0] ec, ei;
      got = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
             alu_src_b, alu_op, imm_src, reg_write};
      exp = exp_ctrl(st, op, zero, mem_ready, rst);
      ec  = CW'(m_cycle);
      ei  = CW'(m_instret);
      checks++;
      if (state !== 4'(st)) begin
         errors++;
         $display("FAIL %s state: got %0d expected %0d", name, state, st);
      end
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s controls (state %0d): got %b expected %b", name, st, got, exp);
      end
      checks++;
      if (cycle_cnt !== ec || instret_cnt !== ei) begin
         errors++;
         $display("FAIL %s counters: got cycle %0d instret %0d expected %0d %0d",
                  name, cycle_cnt, instret_cnt, ec, ei);
      end
      checks++;
      if (illegal !== (m_illegal_pending & first)) begin
         errors++;
         $display("FAIL %s illegal: got %b expected %b", name, illegal,
                  m_illegal_pending & first);
      end
   endtask

   task automatic run_instr(input string name, input logic [6:0] o, input logic z);
      int   seq[$];
      logic adv;
      logic first;
      build_seq(o, seq);
      first = 1'b1;
      foreach (seq[i]) begin
         do begin
            @(negedge clk);
            reset     = 1'b0;
            op        = o;
            zero      = z;
            mem_ready = pick_ready();
            #1;
            check_cycle(name, seq[i], 1'b0, first);
            if (first) m_illegal_pending = 1'b0;
            first = 1'b0;
            adv = !((seq[i] == 0 || seq[i] == 3 || seq[i] == 5) && !mem_ready);
            m_cycle++;
            if (adv && i == seq.size() - 1 && is_legal(o)) m_instret++;
         end while (!adv);
      end
      if (!is_legal(o)) m_illegal_pending = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; op = OpR; zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_cycle("reset", 0, 1'b1, 1'b0);
   endtask

   task automatic test_lw();  run_instr("lw", OpLw, 1'b0);  endtask
   task automatic test_sw();  run_instr("sw", OpSw, 1'b1);  endtask
   task automatic test_jal(); run_instr("jal", OpJal, 1'b0); endtask

   task automatic test_beq();
      run_instr("beq_taken", OpBeq, 1'b1);
      run_instr("beq_not_taken", OpBeq, 1'b0);
   endtask

   task automatic test_illegal();
      run_instr("illegal", 7'b1111111, 1'b0);
      run_instr("after_illegal", OpI, 1'b0);
   endtask

   // Abort an instruction at step k by asserting reset; reset held two cycles
   task automatic test_reset_abort(input string name, input logic [6:0] o, input int k);
      int seq[$];
      build_seq(o, seq);
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         reset = 1'b0; op = o; zero = 1'b1; mem_ready = 1'b1;
         #1;
         check_cycle(name, seq[i], 1'b0, i == 0);
         if (i == 0) m_illegal_pending = 1'b0;
         m_cycle++;
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_cycle(name, seq[k], 1'b1, 1'b0);
      m_cycle = 0; m_instret = 0; m_illegal_pending = 1'b0;
      @(negedge clk);
      #1;
      check_cycle(name, 0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [6:0] ops [6];
      logic [6:0] o;
      ops = '{OpLw, OpSw, OpR, OpI, OpBeq, OpJal};
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            do o = 7'($urandom_range(0, 127)); while (is_legal(o));
         end else begin
            o = ops[$urandom_range(0, 5)];
         end
         run_instr("random", o, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw();
      test_beq();
      test_jal();
      test_illegal();
      test_reset_abort("abort_execr", OpR, 2);
      run_instr("post_abort", OpLw, 1'b0);
      test_reset_abort("abort_aluwb", OpI, 3);
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ucsbece154a_mc_controller.md
Name: ucsbece154a_mc_controller

Overview:
Main control FSM for the multicycle variant of the RISC-V core. It sequences one shared ALU, one unified instruction/data memory port and the register file across Fetch/Decode/Execute/Memory/Writeback steps. It sits inside the core beside the datapath and drives mux selects and write enables from opcode and the ALU zero flag. It also exports performance counters and an illegal-opcode flag.

Parameters:
CNT_WIDTH, 32, width of the cycle_o and instret_o counters; both wrap modulo 2^CNT_WIDTH.

Ports:
clk  input  1  core clock; all state updates on posedge
reset  input  1  synchronous, active-high
op_i  input  7  instruction opcode from the instruction register
zero_i  input  1  ALU zero flag
PCWrite_o  output  1  PC enable = PCUpdate | (Branch & zero_i)
AdrSrc_o  output  1  memory address select: 0 = PC, 1 = Result
MemWrite_o  output  1  memory write enable
IRWrite_o  output  1  instruction register enable
ResultSrc_o  output  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA_o  output  2  00 PC, 01 OldPC, 10 RD1
ALUSrcB_o  output  2  00 ImmExt, 01 RD2, 10 constant 4
ALUOp_o  output  2  00 add, 01 sub, 10 funct-decoded (to external ALU decoder)
ImmSrc_o  output  2  00 I, 01 S, 10 B, 11 J; combinational from op_i
RegWrite_o  output  1  register file write enable
illegal_o  output  1  registered one-cycle pulse on an unknown opcode
state_o  output  4  current state encoding, for debug
cycle_o  output  CNT_WIDTH  cycles since reset deassertion
instret_o  output  CNT_WIDTH  retired instruction count

Behaviour:
- Moore FSM; all controls combinational from state, except PCWrite (uses zero_i) and ImmSrc (uses op_i). Unlisted controls are 0, and unlisted selects are 00.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1 -> DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=00, ALUOp=00. Next state by op_i:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other opcode -> FETCH, with illegal_o=1 on the following cycle.
- MEMADR: ALUSrcA=10, ALUSrcB=00, ALUOp=00. Goes to MEMREAD if op_i=0000011, else MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1 -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 -> FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=01, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
- Instruction latency in cycles: lw 5, sw 4, R/I 4, beq 3, jal 4.
- ImmSrc decode: sw -> 01, beq -> 10, jal -> 11, all other opcodes -> 00.
- Reset:
  - State becomes FETCH; cycle_o, instret_o and illegal_o become 0.
  - While reset=1, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
  - Reset asserted mid-instruction aborts it on the next posedge: no retire, and no further write enables.
- cycle_o: +1 every posedge with reset=0.
- instret_o: +1 on the posedge leaving MEMWB, MEMWRITE, ALUWB or BEQ. An illegal opcode does not retire. Wrap from all-ones to 0 is silent.

Optional Feature:
Macro MC_MEM_WAIT_EN.
- Enabled: adds input mem_ready_i (1 bit).
  - FETCH holds until mem_ready_i=1; IRWrite and PCUpdate are asserted only in that cycle.
  - MEMREAD holds until mem_ready_i=1.
  - MEMWRITE keeps MemWrite=1 every cycle it holds, and advances (and retires) only when mem_ready_i=1.
  - cycle_o still counts wait cycles.
- Disabled: the port is absent and behaviour is identical to mem_ready_i tied to 1.

Test Plan:
- Reset for 2 cycles, then op_i=0000011 (lw) -> states 0,1,2,3,4,0. RegWrite=1 only in state 4; instret_o=1; cycle_o=5.
- op_i=0100011 (sw) -> states 0,1,2,5,0. MemWrite=1 for exactly 1 cycle with AdrSrc=1; ImmSrc=01; instret_o +1.
- op_i=1100011 with zero_i=1 in BEQ -> PCWrite=1 in FETCH and in BEQ. Repeat with zero_i=0 -> PCWrite=0 in BEQ. Each beq takes 3 cycles.
- op_i=1101111 (jal) -> states 0,1,10,8,0. PCWrite=1 in JAL; ALUSrcB=10 in JAL; RegWrite in ALUWB.
- op_i=1111111 -> DECODE returns to FETCH; illegal_o=1 for exactly one cycle; instret_o unchanged. Assert reset during EXECR -> state 0 next cycle, and RegWrite never asserts.
- With MC_MEM_WAIT_EN, lw with mem_ready_i low 3 cycles in FETCH and 2 in MEMREAD -> 10 cycles total; IRWrite=1 for exactly 1 cycle.
